// File: rtl/msg_send_arbiter.sv
// Round-robin arbiter sharing one message sender among N sources: muxes the owner's
// header/count/data onto the sender and routes the sender's address strobes back to it.
module msg_send_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic            Clock,
    input  logic            Clear_n,
    input  logic [N-1:0]    Req,
    output logic [N-1:0]    Grant,
    output logic [IW-1:0]   GrantIdx,
    output logic [N-1:0]    Done,
    input  logic [8*N-1:0]  HeaderBytes,
    input  logic [N-1:0]    LastHeaderBytes,
    input  logic [16*N-1:0] ByteCounts,
    input  logic [8*N-1:0]  DataBytes,
    output logic [N-1:0]    ClearHeaderAddrs,
    output logic [N-1:0]    NextHeaderAddrs,
    output logic [N-1:0]    ClearDataAddrs,
    output logic [N-1:0]    RamReads,
    input  logic            SndReady,
    output logic            SndSend,
    output logic [7:0]      SndHeaderByte,
    output logic            SndLastHeaderByte,
    output logic [15:0]     SndByteCount,
    output logic [7:0]      SndDataByte,
    input  logic            SndClearHeaderAddr,
    input  logic            SndNextHeaderAddr,
    input  logic            SndClearDataAddr,
    input  logic            SndRamRead
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StSettle   = 3'd1;
    localparam logic [2:0] StLaunch   = 3'd2;
    localparam logic [2:0] StWaitDone = 3'd3;
    localparam logic [2:0] StRelease  = 3'd4;

    logic [2:0]    state_q;
    logic [N-1:0]  grant_q;
    logic [IW-1:0] grant_idx_q;
    logic [IW-1:0] ptr_q;

    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand;
    logic [N-1:0]  win_onehot;

    // Search upward from the slot after the last owner, wrapping at N-1.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        cand       = ptr_q;
        win_onehot = '0;
        for (int k = 0; k < N; k++) begin
            cand = (cand == IW'(N - 1)) ? '0 : cand + 1'b1;
            if (!win_found && Req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_onehot[win_idx] = win_found;
    end

    always_ff @(posedge Clock) begin
        if (!Clear_n) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            grant_idx_q <= '0;
            ptr_q       <= IW'(N - 1);
        end else begin
            case (state_q)
                StIdle: begin
                    if (SndReady && win_found) begin
                        grant_q     <= win_onehot;
                        grant_idx_q <= win_idx;
                        state_q     <= StSettle;
                    end
                end
                StSettle: state_q <= StLaunch;
                StLaunch: begin
                    if (!SndReady) state_q <= StWaitDone;
                end
                StWaitDone: begin
                    if (SndReady) state_q <= StRelease;
                end
                StRelease: begin
                    ptr_q       <= grant_idx_q;
                    grant_q     <= '0;
                    grant_idx_q <= '0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign Grant    = grant_q;
    assign GrantIdx = grant_idx_q;
    assign SndSend  = (state_q == StLaunch);
    assign Done     = (state_q == StRelease) ? grant_q : '0;

    // Grant is one-hot or zero, so an AND-OR mux selects the owner or yields zeros.
    always_comb begin
        SndHeaderByte     = '0;
        SndLastHeaderByte = 1'b0;
        SndByteCount      = '0;
        SndDataByte       = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                SndHeaderByte     = SndHeaderByte | HeaderBytes[8*i +: 8];
                SndLastHeaderByte = SndLastHeaderByte | LastHeaderBytes[i];
                SndByteCount      = SndByteCount | ByteCounts[16*i +: 16];
                SndDataByte       = SndDataByte | DataBytes[8*i +: 8];
            end
        end
    end

    assign ClearHeaderAddrs = {N{SndClearHeaderAddr}} & grant_q;
    assign NextHeaderAddrs  = {N{SndNextHeaderAddr}} & grant_q;
    assign ClearDataAddrs   = {N{SndClearDataAddr}} & grant_q;
    assign RamReads         = {N{SndRamRead}} & grant_q;

endmodule

// File: doc/msg_send_arbiter.md
Name: msg_send_arbiter

Overview:
- Shares one message sender (header generator plus data RAM front-end driving a parallel-to-serial shift register) among N message sources.
- Each source owns its own header generator and optional data RAM.
- The block grants the sender round-robin, muxes the granted source's header/count/data onto the sender, and routes the sender's address strobes back to that source only.
- It sits between the per-source message builders and the single sender instance.

Parameters:
- N, 4, number of requesting sources (2..8).
- IW, 2, width of grant index; must be at least ceil(log2(N)).

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- Clear_n  in  1  synchronous, active-low reset.
- Req  in  N  per-source send request; level, held until matching Done.
- Grant  out  N  one-hot; current owner of the sender.
- GrantIdx  out  IW  binary index of the owner (valid while Grant != 0).
- Done  out  N  one-cycle pulse to the owner when its message has fully left the sender.
- HeaderBytes  in  8*N  per-source header byte; source i occupies bits [8i+7:8i].
- LastHeaderBytes  in  N  per-source last-header-byte flag.
- ByteCounts  in  16*N  per-source total byte count; source i occupies bits [16i+15:16i].
- DataBytes  in  8*N  per-source data RAM byte.
- ClearHeaderAddrs, NextHeaderAddrs, ClearDataAddrs, RamReads  out  N each  per-source copies of the sender strobes.
- SndReady  in  1  sender Ready (high = idle).
- SndSend  out  1  sender Send.
- SndHeaderByte  out  8  to sender HeaderByte.
- SndLastHeaderByte  out  1  to sender LastHeaderByte.
- SndByteCount  out  16  to sender ByteCount.
- SndDataByte  out  8  to sender DataByte.
- SndClearHeaderAddr, SndNextHeaderAddr, SndClearDataAddr, SndRamRead  in  1 each  strobes from the sender.

Behaviour:
- Reset (Clear_n=0 at edge):
  - State goes to IDLE; Grant=0, GrantIdx=0, Done=0, SndSend=0.
  - Round-robin pointer goes to N-1, so source 0 wins first.
  - Reset overrides everything, including mid-message. The sender is reset by the same system reset; this block never drives the sender's Clear.
- States:
  - IDLE: if SndReady=1 and Req!=0, pick the winner, register Grant/GrantIdx, go to SETTLE. Otherwise stay.
  - Winner selection: first set bit of Req, searching from pointer+1 upward modulo N.
  - SETTLE: one cycle so the muxed buses are stable at the sender; go to LAUNCH.
  - LAUNCH: SndSend=1. When SndReady=0, go to WAITDONE. SndSend drops on that transition and is never high outside LAUNCH.
  - WAITDONE: when SndReady=1, go to RELEASE.
  - RELEASE: Done[GrantIdx]=1 for exactly this cycle; pointer<=GrantIdx; Grant<=0; go to IDLE.
- Outputs are decoded from the state register (Moore), except the muxes and demuxes below, which are combinational.
- Muxes:
  - SndHeaderByte, SndLastHeaderByte, SndByteCount and SndDataByte are the GrantIdx slice when Grant!=0, otherwise all zeros.
- Demux:
  - ClearHeaderAddrs[i] = SndClearHeaderAddr & Grant[i]; the same rule applies to the other three strobes.
  - With Grant=0, all strobe outputs are 0.
- Latency:
  - Req rising at edge k while IDLE and SndReady=1: Grant valid after edge k+1, SndSend high after edge k+2.
  - Done is issued the cycle after SndReady returns high.
  - Minimum gap between consecutive grants: 1 IDLE cycle.
- Boundary conditions:
  - Req dropped before grant: the request is withdrawn, with no Done.
  - Req dropped after grant: ignored; the message completes and Done still pulses.
  - SndReady=0 while in IDLE (sender busy or still in reset): no grant is made.
  - ByteCount=0 or header-only messages are handled identically; the sequence is driven only by SndReady.
  - Simultaneous requests are resolved round-robin.
  - The owner re-requesting in the RELEASE cycle is only re-granted if no other source is requesting.

Test Plan:
- Single request, source 1 with ByteCount=6 and 4-byte header. Required response: Grant=0010 one cycle after Req; SndSend high one cycle later until SndReady=0; all strobes appear only on index 1; Done[1] pulses once; Grant returns to 0.
- Req=0101 together after reset. Required response: source 0 served first, then source 2. With Req held continuously at 0101, the grant order is 0,2,0,2.
- All four sources requesting continuously. Required response: grant order 0,1,2,3,0; no source granted twice in a row; exactly one Done per message.
- Header-only message (ByteCount=0) on source 3. Required response: SndClearDataAddr and SndRamRead never assert; Done[3] pulses; the next grant proceeds normally.
- Clear_n low for 1 cycle during WAITDONE on source 2. Required response: next cycle Grant=0, SndSend=0, Done=0; pointer reset so a later Req=0101 grants 0 first.
- Req[1] withdrawn after 1 cycle while source 0 owns the sender, and SndReady held low in IDLE for 5 cycles. Required response: source 1 never granted; no grant during the SndReady-low window; grant follows 1 cycle after SndReady rises.
